instr_fetch_unit: RTL and testbench

- Fetch stage that owns the program counter and issues single-outstanding requests to instruction memory.
- Holds the returned word in an instruction register and presents opcode/funct to the control unit.
- Applies the control unit's PC_Select (increment, branch, jump, hold) to compute the next PC when the decoder accepts an instruction.

---
 rtl/cpu_pkg.sv | 23 ++
 rtl/next_pc_calc.sv | 29 ++
 rtl/instr_fetch_unit.sv | 105 ++++++++++
 tb/tb_instr_fetch_unit.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared fetch-stage constants: pc_select codes, fetch states, instruction field positions
package cpu_pkg;

  localparam logic [1:0] PC_INC    = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;
  localparam logic [1:0] PC_HOLD   = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_WAIT  = 2'd2,
    ST_VALID = 2'd3
  } fetch_state_t;

  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 26;
  localparam int FUNCT_MSB  = 5;
  localparam int FUNCT_LSB  = 0;
  localparam int IMM_MSB    = 15;
  localparam int JIDX_MSB   = 25;

endpackage

// File: rtl/next_pc_calc.sv
// rtl/next_pc_calc.sv - combinational next-PC selection: increment, PC-relative branch, pseudo-direct jump
module next_pc_calc
  import cpu_pkg::*;
(
  input  logic [31:0]       pc,
  input  logic [JIDX_MSB:0] instr_idx,
  input  logic [1:0]        pc_select,
  output logic [31:0]       next_pc
);

  logic [31:0] w_pc4;
  logic [31:0] w_br_off;
  logic [31:0] w_jmp_tgt;

  // instr_idx is the jump index field; its low half doubles as the branch immediate
  assign w_pc4     = pc + 32'd4;
  assign w_br_off  = {{14{instr_idx[IMM_MSB]}}, instr_idx[IMM_MSB:0], 2'b00};
  assign w_jmp_tgt = {w_pc4[31:28], instr_idx, 2'b00};

  always_comb begin
    next_pc = w_pc4;
    case (pc_select)
      PC_BRANCH: next_pc = w_pc4 + w_br_off;
      PC_JUMP:   next_pc = w_jmp_tgt;
      default:   next_pc = w_pc4;
    endcase
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - fetch stage with PC, single-outstanding imem request and instruction register
// Optional performance counters fetch_cnt/stall_cnt are built when IFU_PERF_CNT_EN is defined.
module instr_fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          IMEM_ADDR_W = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  output logic                   imem_req,
  output logic [IMEM_ADDR_W-1:0] imem_addr,
  input  logic                   imem_ready,
  input  logic                   imem_rvalid,
  input  logic [31:0]            imem_rdata,
  output logic [31:0]            instr,
  output logic [5:0]             opcode,
  output logic [5:0]             funct,
  output logic [31:0]            pc_out,
  output logic                   instr_valid,
  input  logic                   instr_ready,
  input  logic [1:0]             pc_select
`ifdef IFU_PERF_CNT_EN
  ,
  output logic [31:0]            fetch_cnt,
  output logic [31:0]            stall_cnt
`endif
);

  fetch_state_t r_state;
  logic [31:0]  r_pc;
  logic [31:0]  r_instr;
  logic         r_boot_done;
  logic         w_accept;
  logic [31:0]  w_next_pc;

  assign w_accept = (r_state == ST_VALID) && instr_ready && (pc_select != PC_HOLD);

  next_pc_calc u_next_pc_calc (
    .pc        (r_pc),
    .instr_idx (r_instr[JIDX_MSB:0]),
    .pc_select (pc_select),
    .next_pc   (w_next_pc)
  );

  // IDLE spans one full cycle after reset release, so the first request appears two cycles later
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_pc        <= RESET_PC;
      r_instr     <= '0;
      r_boot_done <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_boot_done <= 1'b1;
          if (r_boot_done) r_state <= ST_REQ;
        end
        ST_REQ: begin
          if (imem_ready) r_state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (imem_rvalid) begin
            r_instr <= imem_rdata;
            r_state <= ST_VALID;
          end
        end
        ST_VALID: begin
          if (w_accept) begin
            r_pc    <= w_next_pc;
            r_state <= ST_REQ;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign imem_req    = (r_state == ST_REQ);
  assign imem_addr   = r_pc[IMEM_ADDR_W-1:0];
  assign instr       = r_instr;
  assign opcode      = r_instr[OPCODE_MSB:OPCODE_LSB];
  assign funct       = r_instr[FUNCT_MSB:FUNCT_LSB];
  assign pc_out      = r_pc;
  assign instr_valid = (r_state == ST_VALID);

`ifdef IFU_PERF_CNT_EN
  logic [31:0] r_fetch_cnt;
  logic [31:0] r_stall_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_fetch_cnt <= '0;
      r_stall_cnt <= '0;
    end else if (r_state == ST_VALID) begin
      if (w_accept) r_fetch_cnt <= r_fetch_cnt + 32'd1;
      else          r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign fetch_cnt = r_fetch_cnt;
  assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - self-checking bench: vector table, randomized fetch stream, reset corner cases
module tb_instr_fetch_unit;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [31:0] pc_out;
  logic        instr_valid;
  logic        instr_ready;
  logic [1:0]  pc_select;
`ifdef IFU_PERF_CNT_EN
  logic [31:0] fetch_cnt;
  logic [31:0] stall_cnt;
`endif

  always #5 clk = ~clk;

  instr_fetch_unit #(.RESET_PC(32'h0000_0000), .IMEM_ADDR_W(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ready  (imem_ready),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .instr       (instr),
    .opcode      (opcode),
    .funct       (funct),
    .pc_out      (pc_out),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .pc_select   (pc_select)
`ifdef IFU_PERF_CNT_EN
    ,
    .fetch_cnt   (fetch_cnt),
    .stall_cnt   (stall_cnt)
`endif
  );

  typedef struct {
    logic [31:0] rdata;
    logic [1:0]  sel;
    logic [31:0] exp_next;
    int          stall;
    int          mode;
  } vec_t;

  vec_t        tbl [14];
  int          checks   = 0;
  int          failures = 0;
  int unsigned m_fetch  = 0;
  int unsigned m_stall  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_next(input logic [31:0] pc, input logic [31:0] ins,
                                           input logic [1:0] sel);
    logic [31:0] pc4;
    int          off;
    pc4 = pc + 32'd4;
    off = int'($signed(ins[15:0])) * 4;
    case (sel)
      2'b01:   return pc4 + 32'(off);
      2'b10:   return (pc4 & 32'hF000_0000) + (32'(ins[25:0]) * 32'd4);
      default: return pc4;
    endcase
  endfunction

  task automatic wait_req();
    for (int i = 0; i < 20; i++) begin
      if (imem_req) break;
      @(negedge clk);
    end
    check("req_timeout", 32'(imem_req), 32'd1);
  endtask

  // mode 0: random mix of hold / not-ready; 1: pure hold; 2: not-ready with imem_ready low
  task automatic fetch_one(input logic [31:0] exp_addr, input logic [31:0] rdata, input int req_dly,
                           input int wait_dly, input int stall, input int mode,
                           input logic [1:0] sel, input string tag);
    wait_req();
    check({tag, "_addr"}, imem_addr, exp_addr);
    for (int i = 0; i < req_dly; i++) begin
      imem_ready  = 1'b0;
      imem_rvalid = 1'($urandom_range(0, 1));
      imem_rdata  = $urandom;
      @(negedge clk);
      check({tag, "_req_hold"}, 32'(imem_req), 32'd1);
      check({tag, "_addr_hold"}, imem_addr, exp_addr);
    end
    imem_rvalid = 1'b0;
    imem_ready  = 1'b1;
    @(negedge clk);
    imem_ready = 1'b0;
    check({tag, "_wait_req"}, 32'(imem_req), 32'd0);
    repeat (wait_dly) @(negedge clk);
    check({tag, "_wait_valid"}, 32'(instr_valid), 32'd0);
    imem_rvalid = 1'b1;
    imem_rdata  = rdata;
    @(negedge clk);
    imem_rvalid = 1'b0;
    imem_rdata  = $urandom;
    check({tag, "_valid"}, 32'(instr_valid), 32'd1);
    check({tag, "_instr"}, instr, rdata);
    check({tag, "_opcode"}, 32'(opcode), 32'(rdata[31:26]));
    check({tag, "_funct"}, 32'(funct), 32'(rdata[5:0]));
    check({tag, "_pc_out"}, pc_out, exp_addr);
    for (int i = 0; i < stall; i++) begin
      if (mode == 1) begin
        instr_ready = 1'b1;
        pc_select   = PC_HOLD;
      end else if (mode == 2) begin
        instr_ready = 1'b0;
        pc_select   = 2'($urandom_range(0, 2));
        imem_ready  = 1'b0;
      end else begin
        instr_ready = 1'($urandom_range(0, 1));
        pc_select   = instr_ready ? PC_HOLD : 2'($urandom_range(0, 3));
        imem_ready  = 1'($urandom_range(0, 1));
        imem_rvalid = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      m_stall++;
      check({tag, "_stall_valid"}, 32'(instr_valid), 32'd1);
      check({tag, "_stall_req"}, 32'(imem_req), 32'd0);
      check({tag, "_stall_instr"}, instr, rdata);
      check({tag, "_stall_pc"}, pc_out, exp_addr);
    end
    imem_ready  = 1'b0;
    imem_rvalid = 1'b0;
    instr_ready = 1'b1;
    pc_select   = sel;
    @(negedge clk);
    m_fetch++;
    instr_ready = 1'b0;
    pc_select   = PC_HOLD;
    check({tag, "_drop"}, 32'(instr_valid), 32'd0);
  endtask

  initial begin
    logic [31:0] pc;
    logic [31:0] rd;
    logic [31:0] exp;
    logic [1:0]  sel;

    tbl[0]  = '{32'h0000_0020, PC_INC,    32'h0000_0004, 0, 0};
    tbl[1]  = '{32'h0800_0004, PC_JUMP,   32'h0000_0010, 0, 0};
    tbl[2]  = '{32'h2222_1111, PC_INC,    32'h0000_0014, 5, 1};
    tbl[3]  = '{32'h0800_0010, PC_JUMP,   32'h0000_0040, 3, 2};
    tbl[4]  = '{32'h1000_FFFE, PC_BRANCH, 32'h0000_003C, 0, 0};
    tbl[5]  = '{32'h0800_0010, PC_JUMP,   32'h0000_0040, 2, 0};
    tbl[6]  = '{32'h1000_0003, PC_BRANCH, 32'h0000_0050, 0, 0};
    tbl[7]  = '{32'h0BFF_FFFF, PC_JUMP,   32'h0FFF_FFFC, 1, 0};
    tbl[8]  = '{32'h0000_0000, PC_INC,    32'h1000_0000, 0, 0};
    tbl[9]  = '{32'h0800_0100, PC_JUMP,   32'h1000_0400, 0, 0};
    tbl[10] = '{32'h1000_8000, PC_BRANCH, 32'h0FFE_0404, 0, 0};
    tbl[11] = '{32'h0800_0000, PC_JUMP,   32'h0000_0000, 0, 0};
    tbl[12] = '{32'h1000_FFFE, PC_BRANCH, 32'hFFFF_FFFC, 0, 0};
    tbl[13] = '{32'hFFFF_FFFF, PC_INC,    32'h0000_0000, 4, 0};

    rst_n       = 1'b0;
    imem_ready  = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    instr_ready = 1'b0;
    pc_select   = PC_HOLD;
    repeat (3) @(negedge clk);
    check("rst_req", 32'(imem_req), 32'd0);
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_instr", instr, 32'd0);
    check("rst_pc", pc_out, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("lat_cycle1_req", 32'(imem_req), 32'd0);
    @(negedge clk);
    check("lat_cycle2_req", 32'(imem_req), 32'd1);
    check("lat_cycle2_addr", imem_addr, 32'd0);

    pc = 32'h0;
    for (int i = 0; i < 14; i++) begin
      fetch_one(pc, tbl[i].rdata, i % 3, (i + 1) % 3, tbl[i].stall, tbl[i].mode, tbl[i].sel, "tbl");
      if (i == 0) begin
        check("first_opcode_sel_funct", 32'(funct), 32'h20);
      end
      check("tbl_next", imem_addr, tbl[i].exp_next);
      pc = tbl[i].exp_next;
    end

    for (int i = 0; i < 40; i++) begin
      rd  = $urandom;
      sel = 2'($urandom_range(0, 2));
      exp = ref_next(pc, rd, sel);
      fetch_one(pc, rd, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                int'($urandom_range(0, 4)), 0, sel, "rnd");
      check("rnd_next", imem_addr, exp);
      pc = exp;
    end

`ifdef IFU_PERF_CNT_EN
    check("perf_fetch", fetch_cnt, m_fetch);
    check("perf_stall", stall_cnt, m_stall);
`endif

    wait_req();
    imem_ready = 1'b1;
    @(negedge clk);
    imem_ready = 1'b0;
    check("midwait_req", 32'(imem_req), 32'd0);
    rst_n = 1'b0;
    @(negedge clk);
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hDEAD_BEEF;
    @(negedge clk);
    rst_n   = 1'b1;
    m_fetch = 0;
    m_stall = 0;
    @(negedge clk);
    check("midwait_valid1", 32'(instr_valid), 32'd0);
    check("midwait_instr", instr, 32'd0);
    check("midwait_req1", 32'(imem_req), 32'd0);
    @(negedge clk);
    check("midwait_valid2", 32'(instr_valid), 32'd0);
    check("midwait_req2", 32'(imem_req), 32'd1);
    check("midwait_addr", imem_addr, 32'd0);
`ifdef IFU_PERF_CNT_EN
    check("perf_fetch_rst", fetch_cnt, 32'd0);
    check("perf_stall_rst", stall_cnt, 32'd0);
`endif
    imem_rvalid = 1'b0;
    fetch_one(32'h0, 32'h0000_0020, 1, 0, 2, 0, PC_INC, "post_rst");
    check("post_rst_next", imem_addr, 32'h4);
`ifdef IFU_PERF_CNT_EN
    check("perf_fetch_end", fetch_cnt, m_fetch);
    check("perf_stall_end", stall_cnt, m_stall);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
